// File: rtl/vector_fetch_seq.sv
// vector_fetch_seq: fetches reset/NMI/IRQ/BRK vectors and loads them into the PC.
// Option VECTOR_FETCH_NMI_HIJACK_EN: a late NMI edge takes over an IRQ/BRK fetch.
module vector_fetch_seq (
  input  logic        clock_ph2,
  input  logic        rst,
  input  logic        sync,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        irq_mask,
  input  logic        brk_req,
  input  logic [7:0]  mem_din,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [7:0]  ADLout,
  output logic [7:0]  ADHout,
  output logic        ADLout_en,
  output logic        ADHout_en,
  output logic [1:0]  vec_src,
  output logic        set_i,
  output logic        ack,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, LOAD} state_t;

  localparam logic [1:0] SRC_RST = 2'b00;
  localparam logic [1:0] SRC_NMI = 2'b01;
  localparam logic [1:0] SRC_IRQ = 2'b10;

  state_t      state_q;
  logic        rst_pend_q;
  logic        nmi_lat_q, nmi_lat_d;
  logic        nmi_prev_q;
  logic [15:0] addr_q;
  logic        rd_q;
  logic [7:0]  adl_q, adh_q;
  logic        load_q;
  logic [1:0]  src_q;

  logic       nmi_edge, nmi_req, irq_act;
  logic       go, hijack, nmi_take;
  logic [1:0] src_sel;

  function automatic logic [15:0] vec_lo(input logic [1:0] s);
    case (s)
      SRC_RST: vec_lo = 16'hFFFC;
      SRC_NMI: vec_lo = 16'hFFFA;
      default: vec_lo = 16'hFFFE;
    endcase
  endfunction

  assign nmi_edge = nmi_prev_q & ~nmi_n;
  assign nmi_req  = nmi_lat_q | nmi_edge;
  assign irq_act  = ~irq_n & ~irq_mask;

  assign go = (state_q == IDLE) &
              (rst_pend_q | (sync & (nmi_req | brk_req | irq_act)));

  always_comb begin
    src_sel = SRC_IRQ;
    if (rst_pend_q)   src_sel = SRC_RST;
    else if (nmi_req) src_sel = SRC_NMI;
  end

`ifdef VECTOR_FETCH_NMI_HIJACK_EN
  assign hijack = (state_q == RD_LO) & (src_q == SRC_IRQ) & nmi_req;
`else
  assign hijack = 1'b0;
`endif

  // an edge arriving on the very cycle the latch is consumed stays latched
  assign nmi_take  = (go & (src_sel == SRC_NMI)) | hijack;
  assign nmi_lat_d = nmi_take ? (nmi_lat_q & nmi_edge)
                              : (nmi_lat_q | nmi_edge);

  always_ff @(posedge clock_ph2) begin
    if (rst) begin
      state_q    <= IDLE;
      rst_pend_q <= 1'b1;
      nmi_lat_q  <= 1'b0;
      nmi_prev_q <= 1'b1;
      addr_q     <= 16'h0000;
      rd_q       <= 1'b0;
      adl_q      <= 8'h00;
      adh_q      <= 8'h00;
      load_q     <= 1'b0;
      src_q      <= SRC_RST;
    end else begin
      nmi_prev_q <= nmi_n;
      nmi_lat_q  <= nmi_lat_d;
      load_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_q <= RD_LO;
            src_q   <= src_sel;
            addr_q  <= vec_lo(src_sel);
            rd_q    <= 1'b1;
            if (src_sel == SRC_RST) rst_pend_q <= 1'b0;
          end
        end
        RD_LO: begin
          if (hijack) begin
            addr_q <= 16'hFFFA;
            src_q  <= SRC_NMI;
          end else begin
            state_q <= RD_HI;
            addr_q  <= addr_q | 16'h0001;
          end
        end
        RD_HI: begin
          state_q <= LOAD;
          rd_q    <= 1'b0;
          adl_q   <= mem_din;
          load_q  <= 1'b1;
        end
        LOAD: begin
          state_q <= IDLE;
          adh_q   <= mem_din;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign ADLout    = adl_q;
  assign ADHout    = (state_q == LOAD) ? mem_din : adh_q;
  assign ADLout_en = load_q;
  assign ADHout_en = load_q;
  assign ack       = load_q;
  assign set_i     = load_q;
  assign vec_src   = src_q;
  assign busy      = ~rst & ((state_q != IDLE) | rst_pend_q);

endmodule

// File: tb/tb_vector_fetch_seq.sv
// tb_vector_fetch_seq: directed bench with read-address and PC-load scoreboards.
// Honours VECTOR_FETCH_NMI_HIJACK_EN for the late-NMI case.
module tb_vector_fetch_seq;

  logic        clk = 1'b0;
  logic        rst, sync, nmi_n, irq_n, irq_mask, brk_req;
  logic [7:0]  mem_din;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  ADLout, ADHout;
  logic        ADLout_en, ADHout_en;
  logic [1:0]  vec_src;
  logic        set_i, ack, busy;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [1:0] src;
  } ld_t;

  logic [15:0] exp_addr[$];
  ld_t         exp_ld[$];
  logic [7:0]  vmem[8];
  int          vectors = 0;
  int          miscompares = 0;
  logic        saw_ack;
  int          n;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd) mem_din <= vmem[mem_addr[2:0]];

  vector_fetch_seq dut (
    .clock_ph2(clk), .rst(rst), .sync(sync), .nmi_n(nmi_n),
    .irq_n(irq_n), .irq_mask(irq_mask), .brk_req(brk_req),
    .mem_din(mem_din), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .ADLout(ADLout), .ADHout(ADHout),
    .ADLout_en(ADLout_en), .ADHout_en(ADHout_en),
    .vec_src(vec_src), .set_i(set_i), .ack(ack), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    ld_t e;
    @(posedge clk);
    @(negedge clk);
    if (mem_rd) begin
      if (exp_addr.size() != 0) chk("rd_addr", mem_addr, exp_addr.pop_front());
      else chk("rd_unexpected", mem_rd, 1'b0);
    end
    if (ack) begin
      saw_ack = 1'b1;
      if (exp_ld.size() != 0) begin
        e = exp_ld.pop_front();
        chk("adl", ADLout, e.lo);
        chk("adh", ADHout, e.hi);
        chk("vec_src", vec_src, e.src);
        chk("adl_en", ADLout_en, 1'b1);
        chk("adh_en", ADHout_en, 1'b1);
        chk("set_i", set_i, 1'b1);
        chk("load_rd", mem_rd, 1'b0);
      end else chk("ack_unexpected", ack, 1'b0);
    end else begin
      chk("pulses_idle", {ADLout_en, ADHout_en, set_i}, 3'b000);
    end
  endtask

  task automatic wait_ack(output int cnt);
    saw_ack = 1'b0;
    cnt = 0;
    while (!saw_ack && cnt < 20) begin
      tick();
      cnt++;
    end
    if (!saw_ack) chk("ack_timeout", saw_ack, 1'b1);
  endtask

  task automatic push_seq(input logic [15:0] a, input logic [7:0] lo,
                          input logic [7:0] hi, input logic [1:0] s);
    exp_addr.push_back(a);
    exp_addr.push_back(a | 16'h0001);
    exp_ld.push_back('{lo: lo, hi: hi, src: s});
  endtask

  initial begin
    vmem[0] = 8'h11; vmem[1] = 8'h22;
    vmem[2] = 8'h34; vmem[3] = 8'h12;
    vmem[4] = 8'h00; vmem[5] = 8'hC0;
    vmem[6] = 8'h78; vmem[7] = 8'h56;
    rst = 1'b1; sync = 1'b0; nmi_n = 1'b1; irq_n = 1'b1;
    irq_mask = 1'b0; brk_req = 1'b0;

    // reset held two cycles
    tick(); tick();
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_rd", mem_rd, 1'b0);
    chk("rst_adl", ADLout, 8'h00);
    chk("rst_adh", ADHout, 8'h00);
    chk("rst_ack", ack, 1'b0);
    chk("rst_src", vec_src, 2'b00);
    chk("rst_busy", busy, 1'b0);

    // reset vector, sync ignored
    rst = 1'b0;
    #1 chk("busy_after_rst", busy, 1'b1);
    push_seq(16'hFFFC, 8'h00, 8'hC0, 2'b00);
    wait_ack(n);
    chk("rst_latency", n, 3);
    tick();
    chk("ack_one_cycle", ack, 1'b0);
    chk("adl_hold", ADLout, 8'h00);
    chk("adh_hold", ADHout, 8'hC0);
    chk("idle_busy", busy, 1'b0);

    // NMI edge latched while sync low
    nmi_n = 1'b0;
    tick();
    nmi_n = 1'b1;
    tick(); tick(); tick();
    chk("nmi_wait_busy", busy, 1'b0);
    push_seq(16'hFFFA, 8'h34, 8'h12, 2'b01);
    sync = 1'b1;
    wait_ack(n);
    chk("nmi_latency", n, 3);
    tick(); tick();
    chk("nmi_once", busy, 1'b0);

    // masked IRQ, then unmasked
    irq_mask = 1'b1; irq_n = 1'b0;
    tick(); tick(); tick(); tick();
    chk("irq_masked", busy, 1'b0);
    push_seq(16'hFFFE, 8'h78, 8'h56, 2'b10);
    irq_mask = 1'b0;
    wait_ack(n);
    chk("irq_latency", n, 3);
    irq_n = 1'b1;
    tick(); tick(); tick();
    chk("irq_done", busy, 1'b0);

    // level IRQ dropped before sync is not serviced
    sync = 1'b0; irq_n = 1'b0;
    tick(); tick();
    irq_n = 1'b1;
    tick();
    sync = 1'b1;
    tick(); tick(); tick();
    chk("irq_cancel", busy, 1'b0);

    // NMI + BRK + IRQ together: NMI first, BRK next
    push_seq(16'hFFFA, 8'h34, 8'h12, 2'b01);
    push_seq(16'hFFFE, 8'h78, 8'h56, 2'b10);
    brk_req = 1'b1; irq_n = 1'b0; nmi_n = 1'b0;
    wait_ack(n);
    wait_ack(n);
    chk("b2b_gap", n, 4);
    brk_req = 1'b0; irq_n = 1'b1; nmi_n = 1'b1;
    tick(); tick(); tick();
    chk("brk_done", busy, 1'b0);

    // reset during RD_HI aborts the IRQ fetch
    exp_addr.push_back(16'hFFFE);
    exp_addr.push_back(16'hFFFF);
    irq_n = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("abort_ack", ack, 1'b0);
    chk("abort_rd", mem_rd, 1'b0);
    chk("abort_src", vec_src, 2'b00);
    rst = 1'b0; irq_n = 1'b1; sync = 1'b0;
    push_seq(16'hFFFC, 8'h00, 8'hC0, 2'b00);
    wait_ack(n);
    chk("rerst_latency", n, 3);
    tick(); tick();

    // NMI edge during IRQ RD_LO
    sync = 1'b1; irq_n = 1'b0;
    exp_addr.push_back(16'hFFFE);
`ifdef VECTOR_FETCH_NMI_HIJACK_EN
    push_seq(16'hFFFA, 8'h34, 8'h12, 2'b01);
`else
    exp_addr.push_back(16'hFFFF);
    exp_ld.push_back('{lo: 8'h78, hi: 8'h56, src: 2'b10});
    push_seq(16'hFFFA, 8'h34, 8'h12, 2'b01);
`endif
    tick();
    nmi_n = 1'b0;
    wait_ack(n);
    irq_n = 1'b1;
`ifndef VECTOR_FETCH_NMI_HIJACK_EN
    wait_ack(n);
    chk("late_nmi_gap", n, 4);
`endif
    nmi_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("late_nmi_done", busy, 1'b0);

    sync = 1'b0;
    tick(); tick();
    chk("addr_left", exp_addr.size(), 0);
    chk("load_left", exp_ld.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_fetch_seq.md
VECTOR_FETCH_SEQ -- requirements
Module: vector_fetch_seq

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high (ports clock_ph2, rst).
REQ-002 clock_ph2  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 sync  in  1  CPU at instruction boundary; a sequence may start only when high (reset sequence excepted).
REQ-005 nmi_n  in  1  active-low NMI; falling edge latched.
REQ-006 irq_n  in  1  active-low level IRQ.
REQ-007 irq_mask  in  1  I flag; 1 blocks IRQ, never NMI/BRK/reset.
REQ-008 brk_req  in  1  decoder BRK request; held high until ack.
REQ-009 mem_din  in  8  read data; valid the cycle after mem_rd=1.
REQ-010 mem_addr  out  16  vector read address.
REQ-011 mem_rd  out  1  memory read strobe.
REQ-012 ADLout, ADHout  out  8 each  vector low/high bytes toward program counter ADL/ADH inputs.
REQ-013 ADLout_en, ADHout_en  out  1 each  PC load enables; one-cycle pulse.
REQ-014 vec_src  out  2  00 reset, 01 NMI, 10 IRQ/BRK; held through the sequence.
REQ-015 set_i  out  1  one-cycle pulse: set interrupt mask.
REQ-016 ack  out  1  one-cycle pulse, coincident with load enables.
REQ-017 busy  out  1  high while state != IDLE or reset pending.

Function
REQ-018 Vectors: NMI $FFFA/$FFFB, reset $FFFC/$FFFD, IRQ/BRK $FFFE/$FFFF.
REQ-019 States IDLE -> RD_LO -> RD_HI -> LOAD -> IDLE; no other transitions except rst.
REQ-020 IDLE: start when reset_pending=1 (sync ignored), else when sync=1 and any request pending; priority reset > NMI > BRK > IRQ(irq_n=0 and irq_mask=0).
REQ-021 RD_LO: mem_addr=vector low address, mem_rd=1.
REQ-022 RD_HI: capture mem_din as low byte; mem_addr=vector high address, mem_rd=1.
REQ-023 LOAD: capture mem_din as high byte; ADLout/ADHout=captured bytes, ADLout_en=ADHout_en=1, ack=1, set_i=1; mem_rd=0.
REQ-024 Latency: start cycle in IDLE to LOAD is exactly 3 cycles; back-to-back sequences SHALL NOT start in the LOAD cycle.
REQ-025 NMI edge detector samples nmi_n every cycle, including during sequences; edge latched until the NMI sequence enters RD_LO.
REQ-026 An NMI edge coinciding with entry to RD_LO of an NMI sequence SHALL remain latched (new edge not lost).
REQ-027 IRQ is level: not latched; deassertion before start cancels it.
REQ-028 reset_pending cleared on entry to RD_LO of the reset sequence.
REQ-029 Outside LOAD: ADLout_en, ADHout_en, ack, set_i = 0; ADLout/ADHout hold last loaded value.
REQ-030 Outside RD_LO/RD_HI: mem_rd=0, mem_addr holds last value.

Reset
REQ-031 While rst=1: state=IDLE, reset_pending=1, NMI latch=0, nmi_n history=1, mem_addr=$0000, mem_rd=0, ADLout=ADHout=$00, all pulses 0, vec_src=00, busy=0.
REQ-032 First cycle after rst falls: busy=1; reset sequence enters RD_LO next edge regardless of sync.
REQ-033 rst mid-sequence aborts with no load pulse; reset sequence restarts after release.

Configuration
REQ-034 Macro VECTOR_FETCH_NMI_HIJACK_EN defined: NMI edge latched during RD_LO of an IRQ/BRK sequence switches RD_HI address to $FFFB, low byte re-read at $FFFA in RD_HI-prior cycle (sequence extended one RD_LO cycle), vec_src=01, NMI latch cleared.
REQ-035 Macro undefined: IRQ/BRK sequence completes unchanged; NMI stays latched and runs next at sync.

Verification
REQ-036 rst 2 cycles, release, mem[$FFFC]=$00, mem[$FFFD]=$C0 -> LOAD 3 cycles after busy, ADLout=$00 ADHout=$C0, vec_src=00, ack=1 one cycle.
REQ-037 nmi_n 1->0 one cycle while sync=0, sync=1 later, mem[$FFFA/B]=$34/$12 -> $1234 loaded, vec_src=01.
REQ-038 irq_n=0 irq_mask=1 sync=1 -> no sequence; mask->0 -> vec_src=10, $FFFE/$FFFF fetched, set_i pulse.
REQ-039 brk_req=1, irq_n=0, NMI edge same cycle, sync=1 -> NMI serviced first, then BRK at next sync.
REQ-040 rst asserted in RD_HI -> no ack, next sequence reads $FFFC; NMI edge in IRQ RD_LO -> $FFFA used with macro, $FFFE then NMI without.
